// File: rtl/axis_pkt_generator_if.sv
// AXI4-Stream transmit channel: data, byte enables, last and valid/ready handshake.
interface axis_pkt_generator_if #(
    parameter int DW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_pkt_generator.sv
// Test-traffic packet source on one AXI4-Stream channel.
// A start request sends cfg_count packets of cfg_len bytes with cfg_gap idle cycles between them.
// Byte k of packet p carries (p + k) mod 256. Beats are formed from registered packet/offset
// state, so tdata/tkeep/tlast stay stable while the sink stalls.
module axis_pkt_generator #(
    parameter int DW    = 128,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkts_sent,
    axis_pkt_generator_if.master axis_tx
);
    localparam int unsigned BYTES = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_off;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pkt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_accept;
    logic             w_send;
    logic [LEN_W-1:0] w_remain;
    logic             w_last_beat;
    logic             w_hs;
    logic             w_pkt_end;
    logic             w_final;
    logic [DW-1:0]    w_tdata;
    logic [BYTES-1:0] w_tkeep;

    assign w_accept    = (r_state == S_IDLE) && start && (cfg_len != '0) && (cfg_count != '0);
    assign w_send      = (r_state == S_SEND);
    assign w_remain    = r_len - r_off;
    assign w_last_beat = (w_remain <= LEN_W'(BYTES));
    assign w_hs        = w_send && axis_tx.tready;
    assign w_pkt_end   = w_hs && w_last_beat;
    assign w_final     = w_pkt_end && ((r_pkt + CNT_W'(1)) == r_count);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: packets back-to-back when gap is zero, no gap after the final packet
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_final) begin
                    w_next = S_DONE;
                end else if (w_pkt_end && (r_gap != '0)) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_next = S_SEND;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Captured configuration, packet index / byte offset and gap countdown
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_len     <= '0;
            r_count   <= '0;
            r_gap     <= '0;
            r_pkt     <= '0;
            r_off     <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_len   <= cfg_len;
                r_count <= cfg_count;
                r_gap   <= cfg_gap;
                r_pkt   <= '0;
                r_off   <= '0;
            end
            if (w_hs) begin
                if (w_last_beat) begin
                    r_off     <= '0;
                    r_pkt     <= r_pkt + CNT_W'(1);
                    r_gap_cnt <= r_gap;
                end else begin
                    r_off <= r_off + LEN_W'(BYTES);
                end
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    // Beat formation: a lane is live while its offset is below the bytes remaining in the packet
    always_comb begin
        w_tdata = '0;
        w_tkeep = '0;
        for (int unsigned j = 0; j < BYTES; j++) begin
            if (w_send && (w_remain > LEN_W'(j))) begin
                w_tkeep[j]       = 1'b1;
                w_tdata[8*j +: 8] = r_pkt[7:0] + r_off[7:0] + 8'(j);
            end
        end
    end

    assign axis_tx.tvalid = w_send;
    assign axis_tx.tdata  = w_tdata;
    assign axis_tx.tkeep  = w_tkeep;
    assign axis_tx.tlast  = w_send && w_last_beat;

    assign busy      = (r_state == S_SEND) || (r_state == S_GAP);
    assign done      = (r_state == S_DONE);
    assign pkts_sent = r_pkt;
endmodule
